pc_next_unit: RTL

//  Registered program-counter stage for the 32-bit single-cycle core; owns the PC flop.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_ras.sv | 58 +++++
 rtl/pc_next_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter stage: next-PC select codes and instruction size.
// Imported by pc_next_unit and pc_ras.
package pc_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // True when an address is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry, and the
// entry count saturates at DEPTH. Instantiated by pc_next_unit only when PC_RAS_EN is defined.
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop_req,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              pop_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [PTR_W-1:0]  top_idx_s;

  // ptr_r is the next free slot, so the newest entry sits one below it (modulo DEPTH).
  assign top_idx_s = ptr_r - PTR_W'(1);
  assign top_data  = mem_r[top_idx_s];
  assign pop_valid = pop_req & (cnt_r != CNT_W'(0));

  // Stack storage, pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= PTR_W'(0);
      cnt_r <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      case ({push, pop_valid})
        2'b11: mem_r[top_idx_s] <= push_data;
        2'b10: begin
          mem_r[ptr_r] <= push_data;
          ptr_r        <= ptr_r + PTR_W'(1);
          if (cnt_r != CNT_W'(DEPTH)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        2'b01: begin
          ptr_r <= top_idx_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: next-PC priority mux (JR > J/JAL > taken branch > PC+4), PC flop,
// redirect and sticky misalignment flags. Define PC_RAS_EN to add the return-address stack.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ctrl_branch,
  input  logic              branch_taken,
  input  logic              ctrl_jump,
  input  logic              ctrl_link,
  input  logic              ctrl_jr,
  input  logic              jr_is_ra,
  input  logic [25:0]       jump_index,
  input  logic [15:0]       branch_offset,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              addr_misalign
);

  logic [ADDR_W-1:0] pc_r;
  logic              redirect_r;
  logic              misalign_r;
  logic [ADDR_W-1:0] br_target_s;
  logic [ADDR_W-1:0] j_target_s;
  logic [ADDR_W-1:0] jr_dest_s;
  logic [ADDR_W-1:0] target_s;
  logic [1:0]        sel_s;

  assign pc_plus4    = pc_r + ADDR_W'(INSTR_BYTES);
  assign br_target_s = pc_plus4 + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign j_target_s  = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] ras_top_s;
  logic              ras_hit_s;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_pc_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ctrl_link & ~stall),
    .pop_req   (ctrl_jr & jr_is_ra & ~stall),
    .push_data (pc_plus4),
    .top_data  (ras_top_s),
    .pop_valid (ras_hit_s)
  );

  // An empty stack falls back to the register-file value.
  assign jr_dest_s = ras_hit_s ? ras_top_s : jr_target;
`else
  logic jr_is_ra_unused_s;
  logic ctrl_link_unused_s;

  assign jr_is_ra_unused_s  = jr_is_ra;
  assign ctrl_link_unused_s = ctrl_link;
  assign jr_dest_s          = jr_target;
`endif

  // Next-PC source selection by fixed priority.
  always_comb begin
    sel_s = NPC_SEQ;
    if (ctrl_jr) begin
      sel_s = NPC_JR;
    end else if (ctrl_jump) begin
      sel_s = NPC_J;
    end else if (ctrl_branch && branch_taken) begin
      sel_s = NPC_BR;
    end else begin
      sel_s = NPC_SEQ;
    end
  end

  // Next-PC value for the selected source.
  always_comb begin
    target_s = pc_plus4;
    case (sel_s)
      NPC_JR:  target_s = jr_dest_s;
      NPC_J:   target_s = j_target_s;
      NPC_BR:  target_s = br_target_s;
      NPC_SEQ: target_s = pc_plus4;
      default: target_s = pc_plus4;
    endcase
  end

  // PC, redirect and sticky misalignment registers; stall freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      redirect_r <= 1'b0;
      misalign_r <= 1'b0;
    end else if (!stall) begin
      pc_r       <= {target_s[ADDR_W-1:2], 2'b00};
      redirect_r <= (sel_s != NPC_SEQ);
      if ((sel_s != NPC_SEQ) && is_misaligned(target_s[1:0])) begin
        misalign_r <= 1'b1;
      end
    end
  end

  assign pc_out        = pc_r;
  assign redirect      = redirect_r;
  assign addr_misalign = misalign_r;

endmodule
